// File: rtl/row_window_gen_pkg.sv
// Shared constants for the row window generator: FSM states, sign codes, padding modes.
package row_window_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

    localparam logic [1:0] SIGN_ZERO = 2'b00;
    localparam logic [1:0] SIGN_POS  = 2'b01;
    localparam logic [1:0] SIGN_NEG  = 2'b10;

    localparam int PAD_ZERO = 0;
    localparam int PAD_EDGE = 1;

    function automatic logic [1:0] sign_code(input logic is_zero, input logic is_neg);
        if (is_zero)
            return SIGN_ZERO;
        else if (is_neg)
            return SIGN_NEG;
        else
            return SIGN_POS;
    endfunction

endpackage

// File: rtl/line_buf.sv
// One row of delay storage: simple dual-port RAM with a registered (1-cycle) read.
module line_buf #(
    parameter int WIDTH_D = 27,
    parameter int DEPTH   = 3584,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH_D-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [WIDTH_D-1:0] rdata
);

    logic [WIDTH_D-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/row_window_gen.sv
// Streams a K-row vertical window (one column per word) over a SIZE x SIZE frame of
// CHANNEL-word pixels, with zero or edge-replicate padding at the top and bottom.
module row_window_gen
    import row_window_gen_pkg::*;
#(
    parameter int WIDTH_D  = 27,
    parameter int SIZE     = 28,
    parameter int CHANNEL  = 128,
    parameter int K        = 3,
    parameter int PAD_MODE = 0
) (
    input  logic                 i_sclk,
    input  logic                 i_rst,
    input  logic                 i_vsync,
    input  logic                 i_valid,
    input  logic [WIDTH_D-1:0]   i_tdata,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WIDTH_D*K-1:0] o_tdata,
    output logic [2*K-1:0]       o_sign,
    output logic                 o_sol,
    output logic                 o_eof,
    output logic                 o_err
);

    localparam int L  = SIZE * CHANNEL;
    localparam int H  = (K - 1) / 2;
    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int RW = $clog2(SIZE + 1);
    localparam int KW = $clog2(K);

    state_t state, state_cur, state_nxt;
    logic [AW-1:0] addr, addr_cur, addr_nxt;
    logic [RW-1:0] row, row_cur, row_nxt, ctr_cur;
    logic step, row_end, last_row, out_en;

    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [WIDTH_D-1:0] din_q;
    logic [RW-1:0]      c_q;
    logic valid_q, sol_q, eof_q, err_q;

    logic [WIDTH_D-1:0] rdata [K-1];
    logic [WIDTH_D-1:0] wdata [K-1];
    logic [WIDTH_D-1:0] raw [K];
    logic [WIDTH_D-1:0] pad [K];
    logic [KW-1:0] lo_idx, hi_idx;

    // i_vsync restarts the frame in the same cycle, so a coincident word lands at address 0.
    always_comb begin
        state_cur = i_vsync ? ST_FILL : state;
        addr_cur  = i_vsync ? '0 : addr;
        row_cur   = i_vsync ? '0 : row;
        step      = (state_cur == ST_FLUSH) ||
                    (i_valid && (state_cur == ST_FILL || state_cur == ST_RUN));
        row_end   = step && (addr_cur == AW'(L - 1));
        last_row  = (state_cur == ST_RUN) ? (row_cur == RW'(SIZE - 1)) : (row_cur == RW'(H - 1));
        out_en    = step && (state_cur == ST_RUN || state_cur == ST_FLUSH);
        ctr_cur   = (state_cur == ST_FLUSH) ? RW'(SIZE - H) + row_cur : row_cur - RW'(H);

        state_nxt = state_cur;
        addr_nxt  = addr_cur;
        row_nxt   = row_cur;
        if (step)
            addr_nxt = row_end ? '0 : addr_cur + 1'b1;
        if (row_end) begin
            row_nxt = row_cur + 1'b1;
            if (last_row) begin
                case (state_cur)
                    ST_FILL:  state_nxt = ST_RUN;
                    ST_RUN: begin
                        state_nxt = ST_FLUSH;
                        row_nxt   = '0;
                    end
                    ST_FLUSH: begin
                        state_nxt = ST_IDLE;
                        row_nxt   = '0;
                    end
                    default:  state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign o_ready = (state != ST_FLUSH);

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            row       <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            sol_q     <= 1'b0;
            eof_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            din_q     <= '0;
            c_q       <= '0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            row     <= row_nxt;
            err_q   <= i_vsync ? 1'b0 : (err_q | (i_valid & ~o_ready));
            valid_q <= out_en;
            sol_q   <= out_en && (addr_cur == '0);
            eof_q   <= out_en && (state_cur == ST_FLUSH) && row_end && last_row;
            wr_en_q <= step;
            if (step) begin
                wr_addr_q <= addr_cur;
                din_q     <= (state_cur == ST_FLUSH) ? '0 : i_tdata;
                c_q       <= ctr_cur;
            end
        end
    end

    // The shift chain is written one cycle after the read, once the RAM data is out.
    for (genvar j = 0; j < K - 1; j++) begin : g_buf
        if (j == 0) begin : g_head
            assign wdata[j] = din_q;
        end else begin : g_tail
            assign wdata[j] = rdata[j-1];
        end
        line_buf #(
            .WIDTH_D(WIDTH_D),
            .DEPTH  (L)
        ) u_line_buf (
            .clk  (i_sclk),
            .we   (wr_en_q),
            .waddr(wr_addr_q),
            .wdata(wdata[j]),
            .raddr(addr_cur),
            .rdata(rdata[j])
        );
    end

    for (genvar k = 0; k < K; k++) begin : g_raw
        if (k == K - 1) begin : g_in
            assign raw[k] = din_q;
        end else begin : g_mem
            assign raw[k] = rdata[K-2-k];
        end
    end

    // Slice holding row 0 (top) or row SIZE-1 (bottom) supplies the edge replica.
    always_comb begin
        lo_idx = KW'(H - int'(c_q));
        hi_idx = KW'(SIZE - 1 + H - int'(c_q));
        for (int k = 0; k < K; k++) begin
            pad[k] = raw[k];
            if (int'(c_q) + k < H)
                pad[k] = (PAD_MODE == PAD_EDGE) ? raw[lo_idx] : '0;
            else if (int'(c_q) + k > SIZE - 1 + H)
                pad[k] = (PAD_MODE == PAD_EDGE) ? raw[hi_idx] : '0;
        end
    end

    always_comb begin
        o_tdata = '0;
        o_sign  = '0;
        for (int k = 0; k < K; k++) begin
            if (valid_q) begin
                o_tdata[k*WIDTH_D +: WIDTH_D] = pad[k];
                o_sign[2*k +: 2] = sign_code(pad[k] == '0, pad[k][WIDTH_D-1]);
            end
        end
    end

    assign o_valid = valid_q;
    assign o_sol   = sol_q;
    assign o_eof   = eof_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_row_window_gen.sv
// Directed bench: two instances (zero and edge padding) share one 4x4, K=3 stimulus stream.
module tb_row_window_gen;

    logic clk = 1'b0;
    logic rst, vsync, valid;
    logic [7:0] tdata;

    logic rdy0, vld0, sol0, eof0, err0;
    logic [23:0] td0;
    logic [5:0] sg0;
    logic rdy1, vld1, sol1, eof1, err1;
    logic [23:0] td1;
    logic [5:0] sg1;

    always #5 clk = ~clk;

    row_window_gen #(.WIDTH_D(8), .SIZE(4), .CHANNEL(1), .K(3), .PAD_MODE(0)) u_dut0 (
        .i_sclk(clk), .i_rst(rst), .i_vsync(vsync), .i_valid(valid), .i_tdata(tdata),
        .o_ready(rdy0), .o_valid(vld0), .o_tdata(td0), .o_sign(sg0),
        .o_sol(sol0), .o_eof(eof0), .o_err(err0)
    );

    row_window_gen #(.WIDTH_D(8), .SIZE(4), .CHANNEL(1), .K(3), .PAD_MODE(1)) u_dut1 (
        .i_sclk(clk), .i_rst(rst), .i_vsync(vsync), .i_valid(valid), .i_tdata(tdata),
        .o_ready(rdy1), .o_valid(vld1), .o_tdata(td1), .o_sign(sg1),
        .o_sol(sol1), .o_eof(eof1), .o_err(err1)
    );

    int checks = 0;
    int errors = 0;
    int n0 = 0;
    int n1 = 0;
    logic [23:0] cap_td  [2][128];
    logic [5:0]  cap_sg  [2][128];
    logic        cap_sol [2][128];
    logic        cap_eof [2][128];

    always @(negedge clk) begin
        if (vld0 && n0 < 128) begin
            cap_td[0][n0]  <= td0;
            cap_sg[0][n0]  <= sg0;
            cap_sol[0][n0] <= sol0;
            cap_eof[0][n0] <= eof0;
            n0 <= n0 + 1;
        end
        if (vld1 && n1 < 128) begin
            cap_td[1][n1]  <= td1;
            cap_sg[1][n1]  <= sg1;
            cap_sol[1][n1] <= sol1;
            cap_eof[1][n1] <= eof1;
            n1 <= n1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic vs, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        vsync = vs;
        tdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] r1c0);
        for (int i = 0; i < 16; i++)
            drive(1'b1, i == 0, (i == 4) ? r1c0 : 8'((i / 4) * 16 + i % 4));
    endtask

    // Expected pixel of row r, column col; rows outside 0..3 follow the padding mode.
    function automatic logic [7:0] px(input int r, input int col, input int pm, input logic [7:0] r1c0);
        int rr;
        rr = r;
        if (r < 0)
            rr = (pm != 0) ? 0 : -1;
        else if (r > 3)
            rr = (pm != 0) ? 3 : -1;
        if (rr < 0)
            return 8'h00;
        if (rr == 1 && col == 0)
            return r1c0;
        return 8'(rr * 16 + col);
    endfunction

    function automatic logic [23:0] exp_col(input int c, input int col, input int pm, input logic [7:0] r1c0);
        return {px(c + 1, col, pm, r1c0), px(c, col, pm, r1c0), px(c - 1, col, pm, r1c0)};
    endfunction

    function automatic logic [5:0] exp_sign(input logic [23:0] w);
        logic [5:0] s;
        logic [7:0] v;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            v = w[8*k +: 8];
            s[2*k +: 2] = (v == 8'h00) ? 2'b00 : (v[7] ? 2'b10 : 2'b01);
        end
        return s;
    endfunction

    task automatic check_frame(input int b, input logic [7:0] r1c0);
        int c;
        int col;
        for (int i = 0; i < 16; i++) begin
            c   = i / 4;
            col = i % 4;
            chk($sformatf("td_zero[%0d]", i), 32'(cap_td[0][b+i]), 32'(exp_col(c, col, 0, r1c0)));
            chk($sformatf("td_edge[%0d]", i), 32'(cap_td[1][b+i]), 32'(exp_col(c, col, 1, r1c0)));
            chk($sformatf("sign_zero[%0d]", i), 32'(cap_sg[0][b+i]), 32'(exp_sign(exp_col(c, col, 0, r1c0))));
            chk($sformatf("sign_edge[%0d]", i), 32'(cap_sg[1][b+i]), 32'(exp_sign(exp_col(c, col, 1, r1c0))));
            chk($sformatf("sol[%0d]", i), 32'(cap_sol[0][b+i]), 32'(col == 0));
            chk($sformatf("eof[%0d]", i), 32'(cap_eof[0][b+i]), 32'(i == 15));
            chk($sformatf("eof_edge[%0d]", i), 32'(cap_eof[1][b+i]), 32'(i == 15));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1;
        vsync = 1'b0;
        valid = 1'b0;
        tdata = 8'h00;

        // reset state
        #3;
        chk("rst_valid", 32'(vld0), 0);
        chk("rst_tdata", 32'(td0), 0);
        chk("rst_sign", 32'(sg0), 0);
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_flags", 32'({sol0, eof0, err0}), 0);
        chk("rst_ready_edge", 32'(rdy1), 1);
        #10 rst = 1'b0;

        // words without a frame start are ignored
        repeat (3) drive(1'b1, 1'b0, 8'hAA);
        idle(3);
        #1;
        chk("no_vsync_out", 32'(n0), 0);

        // clean frame
        base = n0;
        send_frame(8'h10);
        idle(7);
        #1;
        chk("A_count_zero", 32'(n0 - base), 16);
        chk("A_count_edge", 32'(n1 - base), 16);
        chk("A_first_zero", 32'(cap_td[0][base]), 32'h100000);
        chk("A_first_edge", 32'(cap_td[1][base]), 32'h100000);
        chk("A_last_zero", 32'(cap_td[0][base+15]), 32'h003323);
        chk("A_last_edge", 32'(cap_td[1][base+15]), 32'h333323);
        chk("A_err", 32'(err0), 0);
        check_frame(base, 8'h10);

        // negative sample at row 1 col 0
        base = n0;
        send_frame(8'hF0);
        idle(7);
        #1;
        chk("B_count", 32'(n0 - base), 16);
        chk("B_td_neg", 32'(cap_td[0][base]), 32'hF00000);
        chk("B_sign_neg", 32'(cap_sg[0][base]), 32'b100000);
        chk("B_sign_mid", 32'(cap_sg[0][base+4]), 32'b011000);
        chk("B_sign_pos", 32'(cap_sg[0][base+1]), 32'b010100);
        check_frame(base, 8'hF0);

        // overrun during flush
        base = n0;
        send_frame(8'h10);
        drive(1'b1, 1'b0, 8'h55);
        chk("C_ready_low", 32'(rdy0), 0);
        drive(1'b1, 1'b0, 8'h66);
        chk("C_err_set", 32'(err0), 1);
        idle(6);
        #1;
        chk("C_err_sticky", 32'(err0), 1);
        chk("C_ready_back", 32'(rdy0), 1);
        chk("C_count", 32'(n0 - base), 16);
        check_frame(base, 8'h10);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("C_err_clear", 32'(err0), 0);

        // abort after 6 accepted words, then a full frame
        idle(2);
        #1;
        base = n0;
        for (int i = 0; i < 6; i++)
            drive(1'b1, i == 0, 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, 8'((i / 4) * 16 + i % 4));
            if (i == 0) chk("D_valid_before", 32'(vld0), 1);
            if (i == 1) chk("D_valid_drop", 32'(vld0), 0);
        end
        idle(7);
        #1;
        chk("D_count", 32'(n0 - base), 18);
        check_frame(base + 2, 8'h10);

        // asynchronous reset mid-RUN
        for (int i = 0; i < 6; i++)
            drive(1'b1, i == 0, 8'((i / 4) * 16 + i % 4));
        drive(1'b0, 1'b0, 8'h00);
        chk("E_valid_pre", 32'(vld0), 1);
        #2 rst = 1'b1;
        #1;
        chk("E_valid", 32'(vld0), 0);
        chk("E_tdata", 32'(td0), 0);
        chk("E_sign", 32'(sg0), 0);
        chk("E_tdata_edge", 32'(td1), 0);
        chk("E_ready", 32'(rdy0), 1);
        chk("E_flags", 32'({sol0, eof0, err0}), 0);
        #1 rst = 1'b0;
        base = n0;
        repeat (8) drive(1'b1, 1'b0, 8'h42);
        idle(3);
        #1;
        chk("E_no_output", 32'(n0 - base), 0);
        chk("E_valid_idle", 32'(vld0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
